// File: rtl/spi_sclk_gen.sv
// SPI serial clock generator: divides clk_i into bursts of len_i SCLK cycles with lead/trail strobes.
// Optional macro SPI_SCLK_CPOL_EN makes cpol_i select the SCLK idle level; otherwise SCLK idles low.
module spi_sclk_gen #(
    parameter int CNT_W = 16,
    parameter int LEN_W = 6
) (
    input  logic             clk_i,
    input  logic             rst,
    input  logic             en_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] half_div_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             cpol_i,
    output logic             sclk_o,
    output logic             lead_o,
    output logic             trail_o,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic [LEN_W-1:0] edges_q, edges_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             sclk_q, sclk_d;
    logic             lead_q, lead_d;
    logic             trail_q, trail_d;
    logic             done_q, done_d;
    logic             idle_now;
    logic             idle_run;

`ifdef SPI_SCLK_CPOL_EN
    logic cpol_q, cpol_d;
    assign idle_now = cpol_i;
    assign idle_run = cpol_q;
`else
    logic unused_cpol;
    assign unused_cpol = cpol_i;
    assign idle_now    = 1'b0;
    assign idle_run    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        half_d  = half_q;
        edges_d = edges_q;
        len_d   = len_q;
        sclk_d  = sclk_q;
        lead_d  = 1'b0;
        trail_d = 1'b0;
        done_d  = 1'b0;
`ifdef SPI_SCLK_CPOL_EN
        cpol_d  = cpol_q;
`endif
        case (state_q)
            IDLE: begin
                sclk_d  = idle_now;
                cnt_d   = '0;
                edges_d = '0;
                if (start_i && (half_div_i != '0) && (len_i != '0)) begin
                    half_d  = half_div_i;
                    len_d   = len_i;
                    state_d = RUN;
`ifdef SPI_SCLK_CPOL_EN
                    cpol_d  = cpol_i;
`endif
                end
            end
            RUN: begin
                if (en_i) begin
                    if (cnt_q == half_q - CNT_W'(1)) begin
                        cnt_d  = '0;
                        sclk_d = ~sclk_q;
                        // Leaving the idle level is a leading edge; returning to it closes one SCLK cycle.
                        if (sclk_q == idle_run) begin
                            lead_d = 1'b1;
                        end else begin
                            trail_d = 1'b1;
                            edges_d = edges_q + LEN_W'(1);
                            if (edges_q + LEN_W'(1) == len_q) begin
                                done_d  = 1'b1;
                                state_d = IDLE;
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            half_q  <= '0;
            edges_q <= '0;
            len_q   <= '0;
            sclk_q  <= 1'b0;
            lead_q  <= 1'b0;
            trail_q <= 1'b0;
            done_q  <= 1'b0;
`ifdef SPI_SCLK_CPOL_EN
            cpol_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            half_q  <= half_d;
            edges_q <= edges_d;
            len_q   <= len_d;
            sclk_q  <= sclk_d;
            lead_q  <= lead_d;
            trail_q <= trail_d;
            done_q  <= done_d;
`ifdef SPI_SCLK_CPOL_EN
            cpol_q  <= cpol_d;
`endif
        end
    end

    assign sclk_o  = sclk_q;
    assign lead_o  = lead_q;
    assign trail_o = trail_q;
    assign busy_o  = (state_q == RUN);
    assign done_o  = done_q;

endmodule

// File: tb/tb_spi_sclk_gen.sv
// Self-checking bench for spi_sclk_gen: directed bursts plus randomized traffic against a cycle-count model.
// The model derives SCLK from the number of enabled cycles since the accepted start.
module tb_spi_sclk_gen;

    localparam int CNT_W = 16;
    localparam int LEN_W = 6;

`ifdef SPI_SCLK_CPOL_EN
    localparam bit CPOL_EN = 1'b1;
`else
    localparam bit CPOL_EN = 1'b0;
`endif

    logic             clk_i = 1'b0;
    logic             rst;
    logic             en_i;
    logic             start_i;
    logic [CNT_W-1:0] half_div_i;
    logic [LEN_W-1:0] len_i;
    logic             cpol_i;
    logic             sclk_o;
    logic             lead_o;
    logic             trail_o;
    logic             busy_o;
    logic             done_o;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: burst parameters and enabled-cycle count since acceptance.
    bit m_busy, m_sclk, m_lead, m_trail, m_done, m_cpol;
    int m_hd, m_len, m_e;

    spi_sclk_gen #(.CNT_W(CNT_W), .LEN_W(LEN_W)) dut (
        .clk_i      (clk_i),
        .rst        (rst),
        .en_i       (en_i),
        .start_i    (start_i),
        .half_div_i (half_div_i),
        .len_i      (len_i),
        .cpol_i     (cpol_i),
        .sclk_o     (sclk_o),
        .lead_o     (lead_o),
        .trail_o    (trail_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    always #50 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // One clock cycle: drive at negedge, advance the model at posedge, compare just after.
    task automatic applyStimulus(input bit r, input bit s, input bit e,
                                 input int hd, input int ln, input bit cp);
        int ph;
        @(negedge clk_i);
        rst        = r;
        start_i    = s;
        en_i       = e;
        half_div_i = CNT_W'(hd);
        len_i      = LEN_W'(ln);
        cpol_i     = cp;
        @(posedge clk_i);
        m_lead  = 0;
        m_trail = 0;
        m_done  = 0;
        if (!r) begin
            m_busy = 0;
            m_sclk = 0;
            m_e    = 0;
        end else if (!m_busy) begin
            m_sclk = CPOL_EN ? cp : 1'b0;
            if (s && hd != 0 && ln != 0) begin
                m_busy = 1;
                m_hd   = hd;
                m_len  = ln;
                m_cpol = CPOL_EN ? cp : 1'b0;
                m_e    = 0;
            end
        end else if (e) begin
            m_e++;
            if (m_e % m_hd == 0) begin
                ph     = m_e / m_hd;
                m_sclk = m_cpol ^ ph[0];
                if (ph[0]) m_lead = 1;
                else m_trail = 1;
                if (m_e == 2 * m_hd * m_len) begin
                    m_done = 1;
                    m_busy = 0;
                end
            end
        end
        #1;
        checkOutput("sclk", sclk_o, m_sclk);
        checkOutput("lead", lead_o, m_lead);
        checkOutput("trail", trail_o, m_trail);
        checkOutput("busy", busy_o, m_busy);
        checkOutput("done", done_o, m_done);
    endtask

    // Start a burst, optionally drop en_i for a window, and measure it; parameter inputs are scrambled mid-run.
    task automatic runBurst(input int hd, input int ln, input int gap_at, input int gap_len,
                            input bit cp, output int dur, output int leads,
                            output int trails, output int busy_cnt);
        int bound;
        bit en;
        bound    = 4 * hd * ln + gap_len + 20;
        dur      = bound;
        leads    = 0;
        trails   = 0;
        applyStimulus(1, 1, 1, hd, ln, cp);
        busy_cnt = int'(busy_o);
        for (int k = 1; k <= bound; k++) begin
            en = !(k > gap_at && k <= gap_at + gap_len);
            applyStimulus(1, ($urandom % 4) == 0, en, $urandom_range(0, 9),
                          $urandom_range(0, 9), 1'($urandom));
            leads    += int'(lead_o);
            trails   += int'(trail_o);
            busy_cnt += int'(busy_o);
            if (done_o) begin
                dur = k;
                break;
            end
        end
    endtask

    initial begin
        int dur, leads, trails, busy_cnt, edges;
        rst = 0; en_i = 0; start_i = 0; half_div_i = '0; len_i = '0; cpol_i = 0;
        m_busy = 0; m_sclk = 0; m_lead = 0; m_trail = 0; m_done = 0; m_cpol = 0;
        m_hd = 1; m_len = 1; m_e = 0;

        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, 5, 5, 0);
        checkOutput("reset_busy", busy_o, 0);
        applyStimulus(1, 0, 1, 0, 0, 0);

        runBurst(50, 8, 0, 0, 0, dur, leads, trails, busy_cnt);
        checkOutput("b50x8_done_cycle", dur, 800);
        checkOutput("b50x8_leads", leads, 8);
        checkOutput("b50x8_trails", trails, 8);
        checkOutput("b50x8_busy_cycles", busy_cnt, 800);

        runBurst(1, 1, 0, 0, 0, dur, leads, trails, busy_cnt);
        checkOutput("b1x1_done_cycle", dur, 2);
        checkOutput("b1x1_leads", leads, 1);

        runBurst(4, 3, 5, 7, 0, dur, leads, trails, busy_cnt);
        checkOutput("gap7_done_cycle", dur, 31);
        checkOutput("gap7_trails", trails, 3);

        runBurst(4, 2, 0, 0, 1, dur, leads, trails, busy_cnt);
        checkOutput("cpol_done_cycle", dur, 16);
        applyStimulus(1, 0, 1, 4, 2, 1);
        checkOutput("cpol_idle_level", sclk_o, CPOL_EN ? 1 : 0);

        applyStimulus(1, 1, 1, 0, 5, 0);
        checkOutput("start_hd0_busy", busy_o, 0);
        applyStimulus(1, 1, 1, 3, 0, 0);
        checkOutput("start_len0_busy", busy_o, 0);
        applyStimulus(1, 0, 1, 3, 0, 0);
        checkOutput("start_len0_busy_late", busy_o, 0);

        applyStimulus(1, 1, 1, 2, 4, 0);
        edges = 0;
        for (int k = 0; k < 100 && edges < 3; k++) begin
            applyStimulus(1, 0, 1, 2, 4, 0);
            edges += int'(lead_o) + int'(trail_o);
        end
        checkOutput("abort_edges_seen", edges, 3);
        applyStimulus(0, 0, 1, 2, 4, 0);
        checkOutput("abort_sclk", sclk_o, 0);
        checkOutput("abort_busy", busy_o, 0);
        checkOutput("abort_done", done_o, 0);
        applyStimulus(1, 0, 1, 2, 4, 0);
        runBurst(3, 2, 0, 0, 0, dur, leads, trails, busy_cnt);
        checkOutput("post_abort_done_cycle", dur, 12);

        for (int i = 0; i < 4000; i++) begin
            applyStimulus(($urandom % 300) != 0, ($urandom % 5) == 0, ($urandom % 8) != 0,
                          $urandom_range(0, 6), $urandom_range(0, 5), 1'($urandom));
        end

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_sclk_gen.md
SPI_SCLK_GEN -- requirements
Module: spi_sclk_gen

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, giving the width of the half-period divisor.
REQ-002 The block SHALL have parameter LEN_W, default 6, giving the width of the SCLK cycle count per burst.
REQ-003 The block SHALL have port clk_i, input, 1 bit, system clock (10 MHz nominal).
REQ-004 The block SHALL have port rst, input, 1 bit; reset is synchronous and active-low, sampled on clk_i.
REQ-005 The block SHALL have port en_i, input, 1 bit, clock-enable: the divider advances only when high.
REQ-006 The block SHALL have port start_i, input, 1 bit, one-cycle burst request.
REQ-007 The block SHALL have port half_div_i, input, CNT_W bits, clk_i cycles per SCLK half-period.
REQ-008 The block SHALL have port len_i, input, LEN_W bits, number of full SCLK cycles per burst.
REQ-009 The block SHALL have port cpol_i, input, 1 bit, SCLK idle level.
REQ-010 The block SHALL have port sclk_o, output, 1 bit, registered serial clock.
REQ-011 The block SHALL have port lead_o, output, 1 bit, one-cycle strobe on the leading edge (away from idle).
REQ-012 The block SHALL have port trail_o, output, 1 bit, one-cycle strobe on the trailing edge (back to idle).
REQ-013 The block SHALL have port busy_o, output, 1 bit, high while a burst is in progress.
REQ-014 The block SHALL have port done_o, output, 1 bit, one-cycle pulse at burst completion.

Function
REQ-015 The block SHALL implement the states IDLE and RUN; reset enters IDLE.
REQ-016 In IDLE, sclk_o SHALL be loaded each cycle with the idle level; counter = 0; lead_o/trail_o/done_o = 0.
REQ-017 The block SHALL accept start_i in IDLE only if half_div_i != 0 and len_i != 0: it latches both, clears the counters, and enters RUN (busy_o = 1 from the next cycle).
REQ-018 The block SHALL ignore start_i while in RUN or when half_div_i == 0 or len_i == 0 (no busy_o, no done_o).
REQ-019 The block SHALL ignore changes to half_div_i, len_i and cpol_i during RUN; the values latched at start apply.
REQ-020 In RUN with en_i = 1, the counter SHALL increment; at count == half_div_q-1 it SHALL wrap to 0 and toggle sclk_o.
REQ-021 With en_i = 0, the counter, sclk_o and the edge count SHALL hold, and no strobes SHALL be generated.
REQ-022 lead_o/trail_o SHALL be asserted in the same cycle in which sclk_o shows its new level.
REQ-023 The SCLK frequency SHALL be f_clk/(2*half_div); with en_i held high, the first leading edge SHALL appear half_div cycles after the accepting start_i cycle.
REQ-024 Each trailing edge SHALL increment the edge count; when it equals len_q, done_o SHALL pulse together with that trail_o, and the block SHALL return to IDLE (busy_o low in the next cycle).
REQ-025 A burst SHALL last 2*half_div*len cycles of clk_i with en_i held high; start_i in the cycle after done_o SHALL be accepted.
REQ-026 The counter SHALL be CNT_W bits and the edge count LEN_W bits; neither SHALL overflow, because the maximum values are half_div_q-1 and len_q.

Reset
REQ-027 With rst = 0 at a clock edge: state = IDLE, counters = 0, sclk_o = 0, lead_o = trail_o = busy_o = done_o = 0, including during a running burst (aborted without done_o).
REQ-028 Registered strobes that are pending SHALL be cleared by reset; the first edge after reset release SHALL NOT produce any strobe.

Configuration
REQ-029 With macro SPI_SCLK_CPOL_EN defined, the idle level SHALL be cpol_i (latched at start for RUN), so that SPI modes 0-3 are supported.
REQ-030 Without SPI_SCLK_CPOL_EN, cpol_i SHALL be ignored and the idle level SHALL be 0 (port remains present).

Verification
REQ-031 half_div=50, len=8, en_i=1, start_i pulse -> sclk_o 100 kHz, 8 lead_o, 8 trail_o, done_o at cycle 800, busy_o 800 cycles.
REQ-032 half_div=1, len=1 -> sclk_o high for 1 cycle, lead_o at +1, trail_o+done_o at +2, then IDLE.
REQ-033 en_i low for 7 cycles mid-RUN -> counter/sclk_o frozen, burst length extended by exactly 7 cycles.
REQ-034 start_i during RUN, and start_i with len_i=0 or half_div_i=0 -> ignored, no busy_o/done_o change.
REQ-035 rst low during RUN (after 3 edges) -> next cycle sclk_o=0, busy_o=0, no done_o; new start works normally.
REQ-036 SPI_SCLK_CPOL_EN defined, cpol_i=1, half_div=4, len=2 -> sclk_o idles high, lead_o on the falling edges, done_o at cycle 16; undefined -> idle low.
